// File: rtl/spike_pkg.sv
// Shared helpers for the spike event encoders: AER address width and
// saturating counter arithmetic.
package spike_pkg;

    // Address width for n channels, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned aer_addr_w(input int unsigned num);
        return clog2_min1(num);
    endfunction

    // a + b clamped to max; operands are zero-extended counter values.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot grant, binary index and any-valid.
module spike_prio_enc
    import spike_pkg::*;
#(
    parameter int unsigned p_num = 10,
    parameter int unsigned p_aw  = aer_addr_w(p_num)
) (
    input  logic [p_num-1:0] i_req,
    output logic [p_num-1:0] o_grant,
    output logic [p_aw-1:0]  o_idx,
    output logic             o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < p_num; k++) begin
            if (i_req[k] && !o_any) begin
                o_grant[k] = 1'b1;
                o_idx      = p_aw'(k);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises a one-cycle spike vector into AER words, lowest channel first,
// with a valid/ready output and a saturating dropped-event counter.
module spike_aer_encoder
    import spike_pkg::*;
#(
    parameter int unsigned p_num   = 10,
    parameter int unsigned p_aw    = aer_addr_w(p_num),
    parameter int unsigned p_cnt_w = 8
) (
    input  logic               i_clk,
    input  logic               w_reset_n,
    input  logic [p_num-1:0]   i_spike,
    input  logic               i_ready,
    input  logic               i_clear,
    output logic               o_valid,
    output logic [p_aw-1:0]    o_addr,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [p_cnt_w-1:0] o_drop_cnt
);

    localparam logic [p_cnt_w-1:0] CntMax = '1;

    logic [p_num-1:0]   pend_q, pend_d;
    logic               valid_q, valid_d;
    logic [p_aw-1:0]    addr_q, addr_d;
    logic               ovf_q, ovf_d;
    logic [p_cnt_w-1:0] cnt_q, cnt_d;

    logic [p_num-1:0]   grant_oh;
    logic [p_aw-1:0]    grant_idx;
    logic               pend_any;
    logic               slot_free;
    logic               load;
    logic [p_num-1:0]   grant_eff;
    logic [p_num-1:0]   drop_vec;
    logic [31:0]        drops;
    logic [31:0]        cnt_base;
    logic [31:0]        cnt_sum;

    spike_prio_enc #(
        .p_num (p_num),
        .p_aw  (p_aw)
    ) u_prio_enc (
        .i_req   (pend_q),
        .o_grant (grant_oh),
        .o_idx   (grant_idx),
        .o_any   (pend_any)
    );

    always_comb begin
        slot_free = !valid_q || i_ready;
        load      = slot_free && pend_any;
        grant_eff = load ? grant_oh : '0;
        // A granted bit that re-arrives simply stays pending; not a drop.
        pend_d    = (pend_q & ~grant_eff) | i_spike;
        drop_vec  = i_spike & pend_q & ~grant_eff;

        drops = '0;
        for (int k = 0; k < p_num; k++) begin
            drops = drops + 32'(drop_vec[k]);
        end

        valid_d = valid_q;
        addr_d  = addr_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = grant_idx;
        end else if (slot_free) begin
            valid_d = 1'b0;
        end

        // Clear restarts from this cycle's drops so none are lost.
        cnt_base = i_clear ? 32'd0 : 32'(cnt_q);
        cnt_sum  = sat_add(cnt_base, drops, 32'(CntMax));
        cnt_d    = p_cnt_w'(cnt_sum);
        ovf_d    = (ovf_q && !i_clear) || (drops != 32'd0);
    end

    always_ff @(posedge i_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_addr     = addr_q;
    assign o_busy     = (|pend_q) || valid_q;
    assign o_overflow = ovf_q;
    assign o_drop_cnt = cnt_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: default counter width plus a 2-bit
// counter instance sharing the same stimulus.
module tb_spike_aer_encoder;

    logic       i_clk;
    logic       w_reset_n;
    logic [9:0] i_spike;
    logic       i_ready;
    logic       i_clear;

    logic       o_valid;
    logic [3:0] o_addr;
    logic       o_busy;
    logic       o_overflow;
    logic [7:0] o_drop_cnt;

    logic       s_valid;
    logic [3:0] s_addr;
    logic       s_busy;
    logic       s_overflow;
    logic [1:0] s_drop_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    spike_aer_encoder u_dut (
        .i_clk      (i_clk),
        .w_reset_n  (w_reset_n),
        .i_spike    (i_spike),
        .i_ready    (i_ready),
        .i_clear    (i_clear),
        .o_valid    (o_valid),
        .o_addr     (o_addr),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    spike_aer_encoder #(
        .p_num   (10),
        .p_cnt_w (2)
    ) u_dut_c2 (
        .i_clk      (i_clk),
        .w_reset_n  (w_reset_n),
        .i_spike    (i_spike),
        .i_ready    (i_ready),
        .i_clear    (i_clear),
        .o_valid    (s_valid),
        .o_addr     (s_addr),
        .o_busy     (s_busy),
        .o_overflow (s_overflow),
        .o_drop_cnt (s_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then return at the following negedge for sampling/driving.
    task automatic cyc();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic expect_ev(input string tag, input logic [3:0] addr);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_addr"}, 32'(o_addr), 32'(addr));
    endtask

    initial begin
        w_reset_n = 1'b0;
        i_spike   = '0;
        i_ready   = 1'b0;
        i_clear   = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_cnt", 32'(o_drop_cnt), 32'd0);
        w_reset_n = 1'b1;
        cyc();
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Single event on channel 4.
        i_ready = 1'b1;
        i_spike = 10'h010;
        cyc();
        check("single_lat_valid", 32'(o_valid), 32'd0);
        check("single_lat_busy", 32'(o_busy), 32'd1);
        i_spike = '0;
        cyc();
        expect_ev("single", 4'd4);
        check("single_c2_valid", 32'(s_valid), 32'd1);
        check("single_c2_addr", 32'(s_addr), 32'd4);
        cyc();
        check("single_end_valid", 32'(o_valid), 32'd0);
        check("single_end_busy", 32'(o_busy), 32'd0);
        check("single_c2_busy", 32'(s_busy), 32'd0);

        // Burst, ready high: 0,2,5,9 back to back.
        i_spike = 10'b1000100101;
        cyc();
        i_spike = '0;
        cyc();
        expect_ev("burst0", 4'd0);
        cyc();
        expect_ev("burst1", 4'd2);
        cyc();
        expect_ev("burst2", 4'd5);
        cyc();
        expect_ev("burst3", 4'd9);
        cyc();
        check("burst_end_valid", 32'(o_valid), 32'd0);
        check("burst_drops", 32'(o_drop_cnt), 32'd0);

        // Same burst under backpressure.
        i_ready = 1'b0;
        i_spike = 10'b1000100101;
        cyc();
        i_spike = '0;
        cyc();
        expect_ev("bp_hold0", 4'd0);
        cyc();
        expect_ev("bp_hold1", 4'd0);
        cyc();
        expect_ev("bp_hold2", 4'd0);
        i_ready = 1'b1;
        cyc();
        expect_ev("bp_ev1", 4'd2);
        cyc();
        expect_ev("bp_ev2", 4'd5);
        cyc();
        expect_ev("bp_ev3", 4'd9);
        cyc();
        check("bp_end_valid", 32'(o_valid), 32'd0);
        check("bp_drops", 32'(o_drop_cnt), 32'd0);
        check("bp_ovf", 32'(o_overflow), 32'd0);

        // Channel 3 held high 6 cycles while stalled: first re-arrival rides
        // its grant, the next four are drops.
        i_ready = 1'b0;
        i_spike = 10'h008;
        repeat (6) cyc();
        i_spike = '0;
        cyc();
        expect_ev("drop_hold", 4'd3);
        check("drop_ovf", 32'(o_overflow), 32'd1);
        check("drop_cnt8", 32'(o_drop_cnt), 32'd4);
        check("drop_c2_ovf", 32'(s_overflow), 32'd1);
        check("drop_c2_sat", 32'(s_drop_cnt), 32'd3);
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        check("clr_ovf", 32'(o_overflow), 32'd0);
        check("clr_cnt8", 32'(o_drop_cnt), 32'd0);
        check("clr_c2_ovf", 32'(s_overflow), 32'd0);
        check("clr_c2_cnt", 32'(s_drop_cnt), 32'd0);
        i_ready = 1'b1;
        cyc();
        expect_ev("drain_ch3", 4'd3);
        cyc();
        check("drain_valid", 32'(o_valid), 32'd0);
        check("drain_busy", 32'(o_busy), 32'd0);

        // Bit 0 re-arriving on its own grant cycle is not a drop.
        i_spike = 10'h001;
        cyc();
        cyc();
        expect_ev("rearm0", 4'd0);
        check("rearm_cnt", 32'(o_drop_cnt), 32'd0);
        check("rearm_ovf", 32'(o_overflow), 32'd0);
        i_spike = '0;
        cyc();
        expect_ev("rearm1", 4'd0);
        cyc();
        check("rearm_end_valid", 32'(o_valid), 32'd0);

        // Clear colliding with two drops in the same cycle.
        i_ready = 1'b0;
        i_spike = 10'h00E;
        cyc();
        i_spike = '0;
        cyc();
        expect_ev("coll_hold", 4'd1);
        i_spike = 10'h004;
        cyc();
        check("coll_pre_cnt", 32'(o_drop_cnt), 32'd1);
        check("coll_pre_ovf", 32'(o_overflow), 32'd1);
        i_spike = 10'h00C;
        i_clear = 1'b1;
        cyc();
        i_spike = '0;
        i_clear = 1'b0;
        check("coll_cnt8", 32'(o_drop_cnt), 32'd2);
        check("coll_ovf", 32'(o_overflow), 32'd1);
        check("coll_c2_cnt", 32'(s_drop_cnt), 32'd2);
        i_ready = 1'b1;
        cyc();
        expect_ev("coll_ev2", 4'd2);
        cyc();
        expect_ev("coll_ev3", 4'd3);
        cyc();
        check("coll_end_busy", 32'(o_busy), 32'd0);

        // Reset asserted mid-stream clears everything immediately.
        i_spike = 10'b1000100101;
        cyc();
        i_spike = '0;
        cyc();
        expect_ev("mid_pre", 4'd0);
        w_reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_addr", 32'(o_addr), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_ovf", 32'(o_overflow), 32'd0);
        check("mid_rst_cnt", 32'(o_drop_cnt), 32'd0);
        @(negedge i_clk);
        w_reset_n = 1'b1;
        cyc();
        cyc();
        check("post_rst_valid", 32'(o_valid), 32'd0);
        check("post_rst_busy", 32'(o_busy), 32'd0);
        check("post_rst_cnt", 32'(o_drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
